// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and status-flag bit positions.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOT = 4'h0,
    OP_AND = 4'h1,
    OP_OR  = 4'h2,
    OP_XOR = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SUB = 4'h6,
    OP_SBC = 4'h7,
    OP_INC = 4'h8,
    OP_DEC = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_ROL = 4'hC,
    OP_ROR = 4'hD,
    OP_CMP = 4'hE,
    OP_MUL = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds its
// payload stable while valid is high and ready is low, and the receiver samples only on transfer.
interface alu_seq_if #(parameter int WIDTH = 20);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq_step.sv
// One iteration of a shift/rotate (one bit) or of the shift-add multiply (ALU_SEQ_MUL_EN).
module alu_seq_step
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] val_i,
`ifdef ALU_SEQ_MUL_EN
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] hi_o,
`endif
  output logic [WIDTH-1:0] val_o,
  output logic             cout_o
);

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH:0] psum;
`endif

  always_comb begin
    val_o  = val_i;
    cout_o = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    hi_o = hi_i;
    psum = '0;
`endif
    case (op_i)
      OP_SHL: begin
        val_o  = {val_i[WIDTH-2:0], 1'b0};
        cout_o = val_i[WIDTH-1];
      end
      OP_SHR: begin
        val_o  = {1'b0, val_i[WIDTH-1:1]};
        cout_o = val_i[0];
      end
      OP_ROL: begin
        val_o  = {val_i[WIDTH-2:0], val_i[WIDTH-1]};
        cout_o = val_i[WIDTH-1];
      end
      OP_ROR: begin
        val_o  = {val_i[0], val_i[WIDTH-1:1]};
        cout_o = val_i[0];
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        // {hi,lo} holds partial product over the unconsumed multiplier bits in lo.
        psum = {1'b0, hi_i} + (val_i[0] ? {1'b0, mcand_i} : '0);
        {hi_o, val_o} = {psum, val_i[WIDTH-1:1]};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_core.sv
// Multi-cycle ALU with persistent V/C/S/Z status register.
// Optional feature macro: ALU_SEQ_MUL_EN (iterative unsigned multiply on op F).
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus,
  output state_e      dbg_state_o
);

  localparam int SHAMT_W = $clog2(WIDTH) + 1;
  localparam int MSB     = WIDTH - 1;
  localparam logic [SHAMT_W-1:0] WIDTH_N = SHAMT_W'(WIDTH);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   step_hi;
`endif

  op_e                op_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   sc_res, zs;
  logic [3:0]         sc_flags, it_flags;
  logic               c_in, v_in, keep_flags, iter_in;
  logic [SHAMT_W-1:0] steps_in;
  logic [WIDTH-1:0]   step_val;
  logic               step_cout;

  assign op_in = op_e'(bus.op);
  assign shamt = bus.b[SHAMT_W-1:0];

  // Single-cycle results and flags, evaluated from the live operands in IDLE.
  always_comb begin
    sum        = '0;
    sc_res     = '0;
    c_in       = 1'b0;
    v_in       = 1'b0;
    keep_flags = 1'b0;
    iter_in    = 1'b0;
    steps_in   = '0;
    case (op_in)
      OP_NOT: sc_res = ~bus.a;
      OP_AND: sc_res = bus.a & bus.b;
      OP_OR:  sc_res = bus.a | bus.b;
      OP_XOR: sc_res = bus.a ^ bus.b;
      OP_ADD, OP_ADC: begin
        sum    = {1'b0, bus.a} + {1'b0, bus.b}
               + {{WIDTH{1'b0}}, (op_in == OP_ADC) & flags_q[FLAG_C]};
        sc_res = sum[WIDTH-1:0];
        c_in   = sum[WIDTH];
        v_in   = (bus.a[MSB] == bus.b[MSB]) && (sc_res[MSB] != bus.a[MSB]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        sum    = {1'b0, bus.a} + {1'b0, ~bus.b}
               + {{WIDTH{1'b0}}, ~((op_in == OP_SBC) & flags_q[FLAG_C])};
        sc_res = (op_in == OP_CMP) ? bus.a : sum[WIDTH-1:0];
        c_in   = ~sum[WIDTH];
        v_in   = (bus.a[MSB] != bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_INC: begin
        sum    = {1'b0, bus.a} + (WIDTH+1)'(1);
        sc_res = sum[WIDTH-1:0];
        c_in   = sum[WIDTH];
        v_in   = ~bus.a[MSB] & sc_res[MSB];
      end
      OP_DEC: begin
        sum    = {1'b0, bus.a} + {1'b0, {WIDTH{1'b1}}};
        sc_res = sum[WIDTH-1:0];
        c_in   = ~sum[WIDTH];
        v_in   = bus.a[MSB] & ~sc_res[MSB];
      end
      OP_SHL, OP_SHR: begin
        sc_res   = bus.a;
        iter_in  = |shamt;
        steps_in = (shamt > WIDTH_N) ? WIDTH_N : shamt;
      end
      OP_ROL, OP_ROR: begin
        sc_res   = bus.a;
        iter_in  = |shamt;
        steps_in = shamt;
      end
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        iter_in  = 1'b1;
        steps_in = WIDTH_N;
`else
        keep_flags = 1'b1;
`endif
      end
      default: ;
    endcase
    zs = (op_in == OP_CMP) ? sum[WIDTH-1:0] : sc_res;
    sc_flags         = '0;
    sc_flags[FLAG_Z] = ~|zs;
    sc_flags[FLAG_S] = zs[MSB];
    sc_flags[FLAG_C] = c_in;
    sc_flags[FLAG_V] = v_in;
    if (keep_flags) sc_flags = flags_q;
  end

  alu_seq_step #(.WIDTH(WIDTH)) u_step (
    .op_i    (op_q),
    .val_i   (work_q),
`ifdef ALU_SEQ_MUL_EN
    .hi_i    (hi_q),
    .mcand_i (mcand_q),
    .hi_o    (step_hi),
`endif
    .val_o   (step_val),
    .cout_o  (step_cout)
  );

  always_comb begin
    it_flags         = '0;
    it_flags[FLAG_Z] = ~|step_val;
    it_flags[FLAG_S] = step_val[MSB];
    it_flags[FLAG_C] = step_cout;
`ifdef ALU_SEQ_MUL_EN
    if (op_q == OP_MUL) begin
      it_flags[FLAG_C] = |step_hi;
      it_flags[FLAG_V] = |step_hi;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_SEQ_MUL_EN
    hi_d    = hi_q;
    mcand_d = mcand_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d = op_in;
          if (iter_in) begin
            state_d = ST_BUSY;
            cnt_d   = steps_in;
            work_d  = bus.a;
`ifdef ALU_SEQ_MUL_EN
            if (op_in == OP_MUL) begin
              work_d  = bus.b;
              hi_d    = '0;
              mcand_d = bus.a;
            end
`endif
          end else begin
            state_d  = ST_DONE;
            result_d = sc_res;
            flags_d  = sc_flags;
          end
        end
      end
      ST_BUSY: begin
        work_d = step_val;
`ifdef ALU_SEQ_MUL_EN
        hi_d = step_hi;
`endif
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = ST_DONE;
          result_d = step_val;
          flags_d  = it_flags;
        end
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOT;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= '0;
      mcand_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign dbg_state_o   = state_q;

endmodule
